// File: rtl/piso_pkg.sv
// Shared state typedef and encoding constants for the PISO serializer.
package piso_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_SHIFT  = 2'b01;
  localparam logic [1:0] ST_PARITY = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SHIFT  = ST_SHIFT,
    PARITY = ST_PARITY
  } state_e;

endpackage

// File: rtl/piso_bit_cnt.sv
// Data-bit counter for the PISO serializer: runs 0..WIDTH-1, flags the terminal count.
module piso_bit_cnt #(
  parameter int unsigned WIDTH = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic start,
  input  logic en,
  output logic last
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] cnt;

  // A new capture restarts the count even mid-frame (back-to-back frames).
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + ONE;
    end
  end

  assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/last framing and load handshake.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  state_e           state, state_nx;
  logic [WIDTH-1:0] sreg;
  logic             cap;
  logic             cnt_last;
  logic             sbit;

  assign cap  = load_valid && load_ready;
  assign sbit = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];

  piso_bit_cnt #(
    .WIDTH(WIDTH)
  ) u_bit_cnt (
    .clk  (clk),
    .clear(clear),
    .start(cap),
    .en   (state == SHIFT),
    .last (cnt_last)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (cap) state_nx = SHIFT;
      SHIFT: begin
        if (cnt_last) begin
`ifdef PISO_PARITY_EN
          state_nx = PARITY;
`else
          state_nx = cap ? SHIFT : IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: state_nx = cap ? SHIFT : IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Shift so the next frame bit always sits at the output end of the register.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sreg <= '0;
    end else if (cap) begin
      sreg <= d;
    end else if (state == SHIFT) begin
      if (MSB_FIRST != 0) begin
        sreg <= {sreg[WIDTH-2:0], 1'b0};
      end else begin
        sreg <= {1'b0, sreg[WIDTH-1:1]};
      end
    end
  end

`ifdef PISO_PARITY_EN
  logic par;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      par <= 1'b0;
    end else if (cap) begin
      par <= ^d;
    end
  end

  assign sout_last = (state == PARITY);
  assign sout      = (state == SHIFT) ? sbit : ((state == PARITY) ? par : 1'b0);
`else
  assign sout_last = (state == SHIFT) && cnt_last;
  assign sout      = (state == SHIFT) ? sbit : 1'b0;
`endif

  assign busy       = (state != IDLE);
  assign sout_valid = busy;
  assign load_ready = (state == IDLE) || sout_last;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: MSB-first and LSB-first instances driven in parallel,
// checked against directed vector tables and a frame-queue reference model.
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clear;
  logic         load_valid;
  logic [W-1:0] d;

  logic m_ready, m_sout, m_valid, m_last, m_busy;
  logic l_ready, l_sout, l_valid, l_last, l_busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  piso_serializer #(
    .WIDTH    (W),
    .MSB_FIRST(1)
  ) u_msb (
    .clk       (clk),
    .clear     (clear),
    .d         (d),
    .load_valid(load_valid),
    .load_ready(m_ready),
    .sout      (m_sout),
    .sout_valid(m_valid),
    .sout_last (m_last),
    .busy      (m_busy)
  );

  piso_serializer #(
    .WIDTH    (W),
    .MSB_FIRST(0)
  ) u_lsb (
    .clk       (clk),
    .clear     (clear),
    .d         (d),
    .load_valid(load_valid),
    .load_ready(l_ready),
    .sout      (l_sout),
    .sout_valid(l_valid),
    .sout_last (l_last),
    .busy      (l_busy)
  );

  // Reference model: queue of bits still to be sent in the current frame.
  bit qm[$];
  bit ql[$];

  always @(posedge clk or posedge clear) begin
    if (clear) begin
      qm.delete();
      ql.delete();
    end else begin
      bit cap;
      logic [W-1:0] w;
      cap = load_valid && (qm.size() <= 1);
      w   = d;
      if (qm.size() > 0) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (cap) begin
        for (int i = 0; i < W; i++) begin
          qm.push_back(w[W-1-i]);
          ql.push_back(w[i]);
        end
`ifdef PISO_PARITY_EN
        qm.push_back(^w);
        ql.push_back(^w);
`endif
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    logic v, s_m, s_l, lst, rdy;
    v   = (qm.size() > 0);
    s_m = v ? qm[0] : 1'b0;
    s_l = v ? ql[0] : 1'b0;
    lst = (qm.size() == 1);
    rdy = (qm.size() <= 1);
    chk("model msb sout", m_sout, s_m);
    chk("model msb valid", m_valid, v);
    chk("model msb last", m_last, lst);
    chk("model msb ready", m_ready, rdy);
    chk("model msb busy", m_busy, v);
    chk("model lsb sout", l_sout, s_l);
    chk("model lsb valid", l_valid, v);
    chk("model lsb last", l_last, lst);
    chk("model lsb ready", l_ready, rdy);
    chk("model lsb busy", l_busy, v);
  endtask

  task automatic apply(input logic c, input logic lv, input logic [W-1:0] dd);
    @(negedge clk);
    clear      = c;
    load_valid = lv;
    d          = dd;
    #1;
  endtask

  // Each row: inputs held over one cycle and the outputs expected during that cycle.
  typedef struct {
    logic         clr;
    logic         lv;
    logic [W-1:0] d;
    logic         ms;
    logic         ls;
    logic         v;
    logic         l;
    logic         r;
    logic         b;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic clr, input logic lv, input logic [W-1:0] dd,
                              input logic ms, input logic ls, input logic v,
                              input logic l, input logic r, input logic b);
    tbl.push_back('{clr, lv, dd, ms, ls, v, l, r, b});
  endfunction

  function automatic void add_idle(input logic clr, input logic lv, input logic [W-1:0] dd);
    add(clr, lv, dd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction

  initial begin
    clear      = 1'b1;
    load_valid = 1'b0;
    d          = '0;

    add_idle(1, 0, 4'b0000);
    add_idle(0, 1, 4'b1011);
`ifdef PISO_PARITY_EN
    add(0, 0, 4'b0000, 1, 1, 1, 0, 0, 1);
    add(0, 0, 4'b0000, 0, 1, 1, 0, 0, 1);
    add(0, 0, 4'b0000, 1, 0, 1, 0, 0, 1);
    add(0, 0, 4'b0000, 1, 1, 1, 0, 0, 1);
    add(0, 1, 4'b0011, 1, 1, 1, 1, 1, 1);
    add(0, 0, 4'b0000, 0, 1, 1, 0, 0, 1);
    add(0, 0, 4'b0000, 0, 1, 1, 0, 0, 1);
    add(0, 0, 4'b0000, 1, 0, 1, 0, 0, 1);
    add(0, 0, 4'b0000, 1, 0, 1, 0, 0, 1);
    add(0, 0, 4'b0000, 0, 0, 1, 1, 1, 1);
    add_idle(0, 0, 4'b0000);
`else
    add(0, 0, 4'b0000, 1, 1, 1, 0, 0, 1);
    add(0, 0, 4'b0000, 0, 1, 1, 0, 0, 1);
    add(0, 0, 4'b0000, 1, 0, 1, 0, 0, 1);
    add(0, 0, 4'b0000, 1, 1, 1, 1, 1, 1);
    add_idle(0, 1, 4'b0011);
    add(0, 0, 4'b0000, 0, 1, 1, 0, 0, 1);
    add(0, 0, 4'b0000, 0, 1, 1, 0, 0, 1);
    add(0, 0, 4'b0000, 1, 0, 1, 0, 0, 1);
    add(0, 1, 4'b0111, 1, 0, 1, 1, 1, 1);
    add(0, 0, 4'b0000, 0, 1, 1, 0, 0, 1);
    add(0, 0, 4'b0000, 1, 1, 1, 0, 0, 1);
    add(0, 0, 4'b0000, 1, 1, 1, 0, 0, 1);
    add(0, 0, 4'b0000, 1, 0, 1, 1, 1, 1);
    add_idle(0, 1, 4'b1001);
    add(0, 0, 4'b0000, 1, 1, 1, 0, 0, 1);
    add(0, 1, 4'b1111, 0, 0, 1, 0, 0, 1);
    add(0, 0, 4'b0000, 0, 0, 1, 0, 0, 1);
    add(0, 0, 4'b0000, 1, 1, 1, 1, 1, 1);
    add_idle(0, 1, 4'b1011);
    add(0, 0, 4'b0000, 1, 1, 1, 0, 0, 1);
    add(0, 0, 4'b0000, 0, 1, 1, 0, 0, 1);
    add_idle(1, 0, 4'b0000);
    add_idle(0, 0, 4'b0000);
    add_idle(0, 0, 4'b0000);
`endif

    repeat (2) @(negedge clk);

    foreach (tbl[i]) begin
      apply(tbl[i].clr, tbl[i].lv, tbl[i].d);
      chk($sformatf("row%0d msb sout", i), m_sout, tbl[i].ms);
      chk($sformatf("row%0d lsb sout", i), l_sout, tbl[i].ls);
      chk($sformatf("row%0d valid", i), m_valid, tbl[i].v);
      chk($sformatf("row%0d last", i), m_last, tbl[i].l);
      chk($sformatf("row%0d ready", i), m_ready, tbl[i].r);
      chk($sformatf("row%0d busy", i), m_busy, tbl[i].b);
      chk_model();
    end

    for (int n = 0; n < 600; n++) begin
      apply(($urandom_range(0, 49) == 0), 1'($urandom), W'($urandom));
      chk_model();
    end

    apply(1'b1, 1'b0, '0);
    chk_model();
    apply(1'b0, 1'b0, '0);
    chk_model();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
